e_mdu: RTL

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu_pkg.sv | 32 +++
 rtl/e_mdu.sv | 139 +++++++++++++
 2 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: opcode encodings, default latencies and the control FSM state type.
package e_mdu_pkg;

  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd7;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd8;

  localparam int unsigned MDU_MULT_CYCLES_DEFAULT = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic {
    StIdle,
    StBusy
  } mdu_state_e;

  // True for the opcodes that start a multi-cycle operation.
  function automatic logic mdu_is_launch_op(input logic [3:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic mdu_is_mult_op(input logic [3:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Operands are captured at launch; the result is written after a fixed busy period.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_MDU_Ctr,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Busy,
  output logic        E_MDU_Stall,
  output logic [31:0] E_MDU_Out,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  mdu_state_e  r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;
  logic [31:0]        w_div_b;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;
  logic               w_div_zero;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_we;

  // Arithmetic on the captured operands; divisor forced nonzero so the operators stay defined.
  assign w_smul     = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_umul     = {32'd0, r_a} * {32'd0, r_b};
  assign w_div_zero = (r_b == 32'd0);
  assign w_div_b    = w_div_zero ? 32'd1 : r_b;
  assign w_squot    = $signed(r_a) / $signed(w_div_b);
  assign w_srem     = $signed(r_a) % $signed(w_div_b);
  assign w_uquot    = r_a / w_div_b;
  assign w_urem     = r_a % w_div_b;

  // Select the pending HI/LO result for the captured opcode; divide by zero suppresses the write.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_we = 1'b0;
    case (r_op)
      MDU_OP_MULT: begin
        w_res_hi = w_smul[63:32];
        w_res_lo = w_smul[31:0];
        w_res_we = 1'b1;
      end
      MDU_OP_MULTU: begin
        w_res_hi = w_umul[63:32];
        w_res_lo = w_umul[31:0];
        w_res_we = 1'b1;
      end
      MDU_OP_DIV: begin
        w_res_hi = w_srem;
        w_res_lo = w_squot;
        w_res_we = !w_div_zero;
      end
      MDU_OP_DIVU: begin
        w_res_hi = w_urem;
        w_res_lo = w_uquot;
        w_res_we = !w_div_zero;
      end
      default: ;
    endcase
  end

  // Control FSM: launch/capture in idle, count down while busy, commit HI/LO on the last edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 32'd0;
      r_op    <= MDU_OP_NONE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (E_start && mdu_is_launch_op(E_MDU_Ctr)) begin
            r_state <= StBusy;
            r_op    <= E_MDU_Ctr;
            r_a     <= E_A;
            r_b     <= E_B;
            r_cnt   <= mdu_is_mult_op(E_MDU_Ctr) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
          end else if (E_MDU_Ctr == MDU_OP_MTHI) begin
            r_hi <= E_A;
          end else if (E_MDU_Ctr == MDU_OP_MTLO) begin
            r_lo <= E_A;
          end
        end
        StBusy: begin
          // Launch strobes and mthi/mtlo are ignored here.
          if (r_cnt == 32'd1) begin
            r_state <= StIdle;
            r_cnt   <= 32'd0;
            if (w_res_we) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read port for mfhi/mflo, valid regardless of busy.
  always_comb begin
    case (E_MDU_Ctr)
      MDU_OP_MFHI: E_MDU_Out = r_hi;
      MDU_OP_MFLO: E_MDU_Out = r_lo;
      default:     E_MDU_Out = 32'd0;
    endcase
  end

  assign E_Busy      = (r_state == StBusy);
  assign E_MDU_Stall = E_start | E_Busy;
  assign E_HI        = r_hi;
  assign E_LO        = r_lo;

endmodule
